tff_toggle_arbiter: RTL and testbench
=====================================

// Module: tff_toggle_arbiter
// PURPOSE
//  Shares one WIDTH-bit bank of toggle flip-flops between N_REQ requesters.
//  Each requester asks for a toggle with a level req and a per-requester toggle mask.
//  A round-robin arbiter grants one request per slot and drives the bank's t inputs for exactly one cycle.
//  A programmable minimum gap separates consecutive toggles.
//  Sits between the control agents and the T-FF state bank; q is the shared state seen by everyone.
// PARAMETERS
//  N_REQ    4   number of requesters (2..8)
//  WIDTH    4   number of T flip-flops in the bank
//  MIN_GAP  2   idle cycles forced after every grant (0..15)
//  CNT_W    16  width of the grant counter
// PORTS
//  clk         in   1             rising-edge clock
//  rstn        in   1             synchronous reset, active-low
//  req         in   N_REQ         level request per requester; held until its gnt
//  req_mask    in   N_REQ*WIDTH   toggle mask; slice i = bits [i*WIDTH +: WIDTH]
//  gnt         out  N_REQ         one-hot grant/ack, one-cycle pulse
//  t_vec       out  WIDTH         toggle enables into the bank; mask of the granted requester
//  q           out  WIDTH         bank state
//  busy        out  1             high in GRANT and GAP states
//  grant_cnt   out  CNT_W         number of grants issued, wraps modulo 2^CNT_W
// BEHAVIOUR
//  Reset (rstn=0 at a clk edge):
//   - gnt=0, t_vec=0, q=0, busy=0, grant_cnt=0.
//   - state=IDLE, gap counter=0, round-robin pointer=0 (requester 0 has highest priority).
//   - Reset mid-GRANT/GAP aborts immediately: q=0, no toggle at that edge, the pending grant is lost.
//  States:
//   - IDLE: pick the first requester with req=1, scanning from ptr upward modulo N_REQ.
//     If one is found -> GRANT, else stay in IDLE.
//   - GRANT (exactly 1 cycle): gnt[w]=1, t_vec=req_mask slice w captured at the IDLE decision edge.
//     q <= q ^ t_vec at the edge ending GRANT, so the new q is visible one cycle after gnt.
//     At the same edge: grant_cnt+1, ptr <= (w+1) mod N_REQ.
//     Next state: GAP if MIN_GAP>0. If MIN_GAP==0, arbitrate again from the new ptr with w excluded:
//     GRANT if any other request is pending, else IDLE.
//   - GAP: count MIN_GAP cycles with gnt=0 and t_vec=0, then go to IDLE.
//  Latency: req rising in cycle k with no competition in IDLE -> gnt in cycle k+1 -> new q in cycle k+2.
//  Handshake:
//   - The requester drops req in the cycle after gnt.
//   - A req still high in the gnt cycle is ignored for that cycle, since w is excluded from arbitration.
//   - A req still high afterwards is a new request.
//  Masks: an all-zero mask is still granted and counted; q is unchanged.
//   Mask bits are sampled only at the IDLE->GRANT decision edge; later changes have no effect.
//  Simultaneous requests: exactly one grant per slot; the pointer guarantees each pending requester
//   is granted within N_REQ grants. A req that drops before being granted is never granted.
//  Wrap: grant_cnt rolls from 2^CNT_W-1 to 0 with no flag.
//  Outputs gnt, t_vec, busy and q are registered; there is no combinational path from inputs.
// STRUCTURE
//  Shared package tff_ctrl_pkg:
//   - state encoding (IDLE=2'd0, GRANT=2'd1, GAP=2'd2)
//   - gap counter width 4
//   - rr_pick function (round-robin pick with exclude mask)
//  One sub-module, tff_bank: WIDTH T flip-flops with ports clk, rstn, t[WIDTH], q[WIDTH].
//   Sync active-low clear; q toggles where t=1.
//  The arbiter FSM, pointer, gap counter and grant counter stay in the top module.
// TESTING
//  1. Reset hold 2 cycles, then req=0 for 10 cycles -> gnt=0, t_vec=0, q=0, busy=0, grant_cnt=0.
//  2. req=4'b0001, mask0=4'b0101 -> gnt=0001 one cycle later, q=0101 the cycle after.
//     Repeat -> q=0000, grant_cnt=2.
//  3. req=4'b1111 all held until granted, MIN_GAP=2 -> grants 0,1,2,3 in order.
//     Grants are 3 cycles apart; busy stays high throughout.
//  4. ptr=2 after a grant to 1, then req=4'b0011 -> requester 0 granted before 1 (wrap-around).
//  5. rstn=0 in the GRANT cycle with mask 1111 -> q=0, grant_cnt=0, state IDLE.
//     The requester sees gnt for that cycle only.
//  6. CNT_W=4, 17 single-requester grants -> grant_cnt=1; zero-mask grant leaves q unchanged.

Source files
------------

// File: rtl/tff_ctrl_pkg.sv
// Shared definitions for the toggle arbiter: FSM encoding, gap counter width
// and the round-robin pick helper.
package tff_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  localparam int GAP_W   = 4;
  localparam int MAX_REQ = 8;
  localparam int IDX_W   = 3;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } rr_pick_t;

  // First set bit of (reqs & ~excl) scanning from ptr upward modulo n.
  function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] reqs,
                                       input logic [MAX_REQ-1:0] excl,
                                       input logic [IDX_W-1:0]   ptr,
                                       input int                 n);
    rr_pick_t             r;
    logic [MAX_REQ-1:0]   cand;
    int                   j;
    r    = '0;
    cand = reqs & ~excl;
    for (int k = 0; k < MAX_REQ; k++) begin
      j = int'(ptr) + k;
      if (j >= n) j = j - n;
      if (k < n && !r.found && cand[j[IDX_W-1:0]]) begin
        r.found = 1'b1;
        r.idx   = j[IDX_W-1:0];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/tff_bank.sv
// Bank of WIDTH toggle flip-flops with synchronous active-low clear.
module tff_bank #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] t,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  always_comb begin
    q_d = q_q ^ t;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/tff_toggle_arbiter.sv
// Round-robin arbiter sharing one T-FF bank between N_REQ requesters, with a
// programmable idle gap after every grant.
module tff_toggle_arbiter
  import tff_ctrl_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int WIDTH   = 4,
  parameter int MIN_GAP = 2,
  parameter int CNT_W   = 16
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] req_mask,
  output logic [N_REQ-1:0]       gnt,
  output logic [WIDTH-1:0]       t_vec,
  output logic [WIDTH-1:0]       q,
  output logic                   busy,
  output logic [CNT_W-1:0]       grant_cnt
);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   w_q, w_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic [WIDTH-1:0]   t_vec_q, t_vec_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [MAX_REQ-1:0] req_ext;
  logic [MAX_REQ-1:0] w_excl;
  logic [IDX_W-1:0]   next_ptr;
  rr_pick_t           pick_idle;
  rr_pick_t           pick_regrant;
  logic               launch;
  logic [IDX_W-1:0]   launch_idx;

  assign req_ext  = MAX_REQ'(req);
  assign w_excl   = MAX_REQ'(1) << w_q;
  assign next_ptr = (w_q == IDX_W'(N_REQ - 1)) ? '0 : w_q + IDX_W'(1);

  // Back-to-back arbitration (MIN_GAP==0) must use the advanced pointer and
  // skip the requester that is being acknowledged this cycle.
  assign pick_idle    = rr_pick(req_ext, '0, ptr_q, N_REQ);
  assign pick_regrant = rr_pick(req_ext, w_excl, next_ptr, N_REQ);

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    w_d        = w_q;
    gap_d      = gap_q;
    gnt_d      = '0;
    t_vec_d    = '0;
    cnt_d      = cnt_q;
    launch     = 1'b0;
    launch_idx = pick_idle.idx;

    case (state_q)
      ST_IDLE: begin
        if (pick_idle.found) launch = 1'b1;
      end
      ST_GRANT: begin
        cnt_d = cnt_q + CNT_W'(1);
        ptr_d = next_ptr;
        if (MIN_GAP > 0) begin
          state_d = ST_GAP;
          gap_d   = GAP_W'(MIN_GAP - 1);
        end else if (pick_regrant.found) begin
          launch     = 1'b1;
          launch_idx = pick_regrant.idx;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GAP: begin
        // The final gap cycle doubles as the idle decision, so a waiting
        // request is granted without an extra idle cycle.
        if (gap_q == '0) begin
          if (pick_idle.found) launch = 1'b1;
          else                 state_d = ST_IDLE;
        end else begin
          gap_d = gap_q - GAP_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (launch) begin
      state_d = ST_GRANT;
      w_d     = launch_idx;
      for (int i = 0; i < N_REQ; i++) begin
        gnt_d[i] = (launch_idx == IDX_W'(i));
        if (launch_idx == IDX_W'(i)) t_vec_d = req_mask[i*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      w_q     <= '0;
      gap_q   <= '0;
      gnt_q   <= '0;
      t_vec_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      w_q     <= w_d;
      gap_q   <= gap_d;
      gnt_q   <= gnt_d;
      t_vec_q <= t_vec_d;
      cnt_q   <= cnt_d;
    end
  end

  tff_bank #(.WIDTH(WIDTH)) u_bank (
    .clk  (clk),
    .rstn (rstn),
    .t    (t_vec_q),
    .q    (q)
  );

  assign gnt       = gnt_q;
  assign t_vec     = t_vec_q;
  assign busy      = (state_q != ST_IDLE);
  assign grant_cnt = cnt_q;

endmodule

// File: tb/tb_tff_toggle_arbiter.sv
// Scoreboard bench for tff_toggle_arbiter: drivers push expected grants, a
// negedge monitor pops them when gnt appears and checks q/grant_cnt one cycle later.
module tb_tff_toggle_arbiter;

  localparam int N_REQ   = 4;
  localparam int WIDTH   = 4;
  localparam int MIN_GAP = 2;
  localparam int CNT_W   = 4;

  logic                   clk = 1'b0;
  logic                   rstn;
  logic [N_REQ-1:0]       req;
  logic [N_REQ*WIDTH-1:0] req_mask;
  logic [N_REQ-1:0]       gnt;
  logic [WIDTH-1:0]       t_vec;
  logic [WIDTH-1:0]       q;
  logic                   busy;
  logic [CNT_W-1:0]       grant_cnt;

  tff_toggle_arbiter #(
    .N_REQ(N_REQ), .WIDTH(WIDTH), .MIN_GAP(MIN_GAP), .CNT_W(CNT_W)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .req       (req),
    .req_mask  (req_mask),
    .gnt       (gnt),
    .t_vec     (t_vec),
    .q         (q),
    .busy      (busy),
    .grant_cnt (grant_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N_REQ-1:0] gnt;
    logic [WIDTH-1:0] t;
    logic [WIDTH-1:0] q;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  logic [WIDTH-1:0] mq   = '0;
  logic [CNT_W-1:0] mcnt = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int i, input logic [WIDTH-1:0] m, input logic rst_abort);
    exp_t e;
    e.gnt = N_REQ'(1) << i;
    e.t   = m;
    if (rst_abort) begin
      mq   = '0;
      mcnt = '0;
    end else begin
      mq   = mq ^ m;
      mcnt = mcnt + CNT_W'(1);
    end
    e.q   = mq;
    e.cnt = mcnt;
    sb.push_back(e);
  endtask

  task automatic wait_idle;
    for (int n = 0; n < 20 && busy; n++) tick;
    chk("idle_wait", {31'd0, busy}, 32'd0);
  endtask

  // One uncontended request from IDLE: grant must appear exactly one cycle later.
  task automatic single(input int i, input logic [WIDTH-1:0] m);
    wait_idle;
    push_exp(i, m, 1'b0);
    req_mask[i*WIDTH +: WIDTH] = m;
    req[i] = 1'b1;
    tick;
    chk("latency_gnt", 32'(gnt), 32'(N_REQ'(1) << i));
    req[i] = 1'b0;
  endtask

  // Monitor
  exp_t pend;
  logic post_pending = 1'b0;
  always @(negedge clk) begin
    if (post_pending) begin
      chk("post_q", 32'(q), 32'(pend.q));
      chk("post_cnt", 32'(grant_cnt), 32'(pend.cnt));
      post_pending = 1'b0;
    end
    if (!$isunknown(gnt) && gnt != '0) begin
      if (sb.size() == 0) begin
        chk("unexpected_gnt", 32'(gnt), 32'd0);
      end else begin
        pend = sb.pop_front();
        chk("gnt", 32'(gnt), 32'(pend.gnt));
        chk("t_vec", 32'(t_vec), 32'(pend.t));
        post_pending = 1'b1;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int prev;
    rstn     = 1'b0;
    req      = '0;
    req_mask = '0;

    // 1: reset then idle
    tick; tick;
    rstn = 1'b1;
    for (int n = 0; n < 10; n++) begin
      tick;
      chk("idle_gnt", 32'(gnt), 32'd0);
    end
    chk("idle_t_vec", 32'(t_vec), 32'd0);
    chk("idle_q", 32'(q), 32'd0);
    chk("idle_busy", {31'd0, busy}, 32'd0);
    chk("idle_cnt", 32'(grant_cnt), 32'd0);

    // 2: single requester toggling twice
    single(0, 4'b0101);
    single(0, 4'b0101);
    wait_idle;
    chk("t2_q", 32'(q), 32'h0);
    chk("t2_cnt", 32'(grant_cnt), 32'd2);

    // Re-centre the pointer at 0 for the ordering test
    rstn = 1'b0;
    tick; tick;
    rstn = 1'b1;
    mq   = '0;
    mcnt = '0;

    // 3: all four requesting, grants 0..3 three cycles apart, busy held
    req_mask = {4'b1000, 4'b0100, 4'b0010, 4'b0001};
    for (int i = 0; i < N_REQ; i++) push_exp(i, req_mask[i*WIDTH +: WIDTH], 1'b0);
    req  = 4'hF;
    prev = -1;
    for (int c = 0; c < 40 && req != '0; c++) begin
      tick;
      if (gnt != '0) begin
        if (prev >= 0) chk("t3_spacing", 32'(c - prev), 32'd3);
        prev = c;
        req  = req & ~gnt;
      end else if (prev >= 0) begin
        chk("t3_busy", {31'd0, busy}, 32'd1);
      end
    end
    chk("t3_done", 32'(req), 32'd0);

    // 4: wrap-around; zero-mask grant to 1 leaves q alone, then 0 beats 1
    single(1, 4'b0000);
    wait_idle;
    req_mask[0 +: WIDTH]     = 4'b0011;
    req_mask[WIDTH +: WIDTH] = 4'b1100;
    push_exp(0, 4'b0011, 1'b0);
    push_exp(1, 4'b1100, 1'b0);
    req = 4'b0011;
    for (int c = 0; c < 30 && req != '0; c++) begin
      tick;
      if (gnt != '0) req = req & ~gnt;
    end
    chk("t4_done", 32'(req), 32'd0);
    wait_idle;
    chk("t4_q", 32'(q), 32'h0);

    // 5: reset during the GRANT cycle aborts the toggle
    wait_idle;
    push_exp(2, 4'b1111, 1'b1);
    req_mask[2*WIDTH +: WIDTH] = 4'b1111;
    req[2] = 1'b1;
    tick;
    chk("t5_gnt", 32'(gnt), 32'b0100);
    rstn   = 1'b0;
    req[2] = 1'b0;
    tick;
    rstn = 1'b1;
    chk("t5_q", 32'(q), 32'd0);
    chk("t5_cnt", 32'(grant_cnt), 32'd0);
    chk("t5_gnt_gone", 32'(gnt), 32'd0);
    chk("t5_busy", {31'd0, busy}, 32'd0);

    // 6: 17 grants wrap a 4-bit counter to 1
    for (int n = 0; n < 17; n++) single(n % N_REQ, WIDTH'(n));
    wait_idle;
    tick;
    chk("t6_cnt", 32'(grant_cnt), 32'd1);
    chk("t6_q", 32'(q), 32'(mq));

    for (int n = 0; n < 4; n++) tick;
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
